// File: rtl/wb_fifo_pkg.sv
// ============================================================================
// Module      : wb_fifo_pkg
// Description : Shared types and helpers for the Wishbone pipelined FIFO.
//               ctrl_state_e enumerates the downstream controller states;
//               level_width() sizes an entry counter able to hold 0..DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_fifo_pkg;

    typedef enum logic [1:0] {
        CS_IDLE = 2'd0,
        CS_REQ  = 2'd1,
        CS_WAIT = 2'd2
    } ctrl_state_e;

    // A counter for 2**addr_width entries must also represent the full value.
    function automatic int level_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_fifo_if.sv
// ============================================================================
// Module      : wb_fifo_if
// Description : Wishbone pipelined bus bundle.
//               master drives cyc/stb/we/dat_m, slave drives dat_s/stall/
//               ack/err.
// Ports       : cyc, stb, we, dat_m (master -> slave)
//               dat_s, stall, ack, err (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [DATA_WIDTH-1:0] dat_m;
    logic [DATA_WIDTH-1:0] dat_s;
    logic                  stall;
    logic                  ack;
    logic                  err;

    modport master (output cyc, stb, we, dat_m, input dat_s, stall, ack, err);
    modport slave  (input cyc, stb, we, dat_m, output dat_s, stall, ack, err);
endinterface

`default_nettype wire

// File: rtl/wb_fifo_ptr.sv
// ============================================================================
// Module      : wb_fifo_ptr
// Description : Wrapping FIFO pointer, modulo 2**ADDR_WIDTH. clr has
//               priority over inc.
// Ports       : clk_i, rst_ni  - clock, async active-low reset
//               inc, clr       - advance / return to zero
//               ptr            - current pointer
//               ptr_next       - ptr + 1 (wrapped), for look-ahead reads
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo_ptr #(
    parameter int ADDR_WIDTH = 4
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_ni,
    input  wire logic                  inc,
    input  wire logic                  clr,
    output logic      [ADDR_WIDTH-1:0] ptr,
    output logic      [ADDR_WIDTH-1:0] ptr_next
);

    assign ptr_next = ptr + ADDR_WIDTH'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_fifo_pipe.sv
// ============================================================================
// Module      : wb_fifo_pipe
// Description : Parametrised Wishbone pipelined FIFO. Upstream is a device
//               port (write = push, read = level). Downstream is a controller
//               port draining entries as single write cycles, retrying the
//               head on err. Synchronous flush, level and threshold flags.
// Ports       : clk_i, rst_ni  - clock, async active-low reset
//               flush_i        - synchronous discard of all entries
//               wbi            - upstream Wishbone (slave modport)
//               wbo            - downstream Wishbone (master modport)
//               level_o        - entry count 0..DEPTH
//               full_o, empty_o, almost_full_o, almost_empty_o - flags
// Macro       : WB_FIFO_BURST_EN - keep cyc high and chain entries back to
//               back (2 cycles/entry) when more than one entry is queued.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo_pipe
    import wb_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int AE_THRESH  = 2
) (
    input  wire logic                                clk_i,
    input  wire logic                                rst_ni,
    input  wire logic                                flush_i,
    wb_fifo_if.slave                                 wbi,
    wb_fifo_if.master                                wbo,
    output logic      [level_width(ADDR_WIDTH)-1:0]  level_o,
    output logic                                     full_o,
    output logic                                     empty_o,
    output logic                                     almost_full_o,
    output logic                                     almost_empty_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LW    = level_width(ADDR_WIDTH);

    localparam logic [1:0] S_IDLE = CS_IDLE;
    localparam logic [1:0] S_REQ  = CS_REQ;
    localparam logic [1:0] S_WAIT = CS_WAIT;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]         level;
    logic [ADDR_WIDTH-1:0] rd_ptr, rd_ptr_next, wr_ptr, wr_ptr_next;

    logic                  accept, push, rd, pop;
    logic                  up_ack;
    logic [DATA_WIDTH-1:0] up_dat;

    logic [1:0]            state;
    logic                  dn_cyc, dn_stb, in_flight;
    logic [DATA_WIDTH-1:0] dn_dat;

    // ---------------------------------------------------------------- flags
    assign level_o        = level;
    assign full_o         = (level == LW'(DEPTH));
    assign empty_o        = (level == '0);
    assign almost_full_o  = (level >= LW'(AF_THRESH));
    assign almost_empty_o = (level <= LW'(AE_THRESH));

    // ------------------------------------------------------------- upstream
    // Stall comes straight from the registered level, so a push can never
    // land on a full FIFO.
    assign accept = wbi.cyc & wbi.stb & ~full_o;
    assign push   = accept & wbi.we & ~flush_i;
    assign rd     = accept & ~wbi.we;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            up_ack <= 1'b0;
            up_dat <= '0;
        end else begin
            up_ack <= accept;
            up_dat <= rd ? DATA_WIDTH'(level) : '0;
        end
    end

    assign wbi.stall = full_o;
    assign wbi.ack   = up_ack;
    assign wbi.dat_s = up_dat;
    assign wbi.err   = 1'b0;

    // ------------------------------------------------------ storage, level
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wbi.dat_m;
        end
    end

    // Only an ack for a cycle that is still owned (not flushed) retires
    // the head; err leaves it in place for a retry.
    assign pop = (state == S_WAIT) & wbo.ack & ~wbo.err & in_flight & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level <= '0;
        end else if (flush_i) begin
            level <= '0;
        end else if (push && !pop) begin
            level <= level + LW'(1);
        end else if (pop && !push) begin
            level <= level - LW'(1);
        end
    end

    wb_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .inc      (push),
        .clr      (flush_i),
        .ptr      (wr_ptr),
        .ptr_next (wr_ptr_next)
    );

    wb_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .inc      (pop),
        .clr      (flush_i),
        .ptr      (rd_ptr),
        .ptr_next (rd_ptr_next)
    );

    // ------------------------------------------------ downstream controller
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= S_IDLE;
            dn_cyc    <= 1'b0;
            dn_stb    <= 1'b0;
            dn_dat    <= '0;
            in_flight <= 1'b0;
        end else begin
            // A flushed cycle still completes on the bus but no longer owns
            // an entry.
            if (flush_i) begin
                in_flight <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (!empty_o && !flush_i) begin
                        state     <= S_REQ;
                        dn_cyc    <= 1'b1;
                        dn_stb    <= 1'b1;
                        dn_dat    <= mem[rd_ptr];
                        in_flight <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (!wbo.stall) begin
                        state  <= S_WAIT;
                        dn_stb <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (wbo.err) begin
                        state     <= S_IDLE;
                        dn_cyc    <= 1'b0;
                        in_flight <= 1'b0;
                    end else if (wbo.ack) begin
`ifdef WB_FIFO_BURST_EN
                        // level > 1 guarantees a further entry behind the
                        // one popping now.
                        if (in_flight && !flush_i && level > LW'(1)) begin
                            state  <= S_REQ;
                            dn_stb <= 1'b1;
                            dn_dat <= mem[rd_ptr_next];
                        end else begin
                            state     <= S_IDLE;
                            dn_cyc    <= 1'b0;
                            in_flight <= 1'b0;
                        end
`else
                        state     <= S_IDLE;
                        dn_cyc    <= 1'b0;
                        in_flight <= 1'b0;
`endif
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    dn_cyc    <= 1'b0;
                    dn_stb    <= 1'b0;
                    in_flight <= 1'b0;
                end
            endcase
        end
    end

    assign wbo.cyc   = dn_cyc;
    assign wbo.stb   = dn_stb;
    assign wbo.we    = dn_cyc;
    assign wbo.dat_m = dn_dat;

    logic unused_ok;
    assign unused_ok = ^{wbo.dat_s, wr_ptr_next, rd_ptr_next};

endmodule

`default_nettype wire

// File: doc/wb_fifo_pipe.md
Name: wb_fifo_pipe

Overview:
Parametrised Wishbone pipelined FIFO. Successor to the 8-bit, fixed-depth FIFO.
- Upstream side is a device port: push by write, level readback by read.
- Downstream side is a controller port that drains entries as single write cycles, with stall/err handling and retry.
- Adds programmable width, almost-full/almost-empty flags, level output and synchronous flush. Sits between a Wishbone producer and a slow Wishbone sink (e.g. a UART TX).

Parameters:
DATA_WIDTH, 8, data bits per entry
ADDR_WIDTH, 4, log2 depth; DEPTH = 2**ADDR_WIDTH
AF_THRESH, DEPTH-2, almost_full_o when level >= AF_THRESH
AE_THRESH, 2, almost_empty_o when level <= AE_THRESH

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
flush_i  in  1  sync flush, discards contents
wbi_cyc_i  in  1  upstream cycle
wbi_stb_i  in  1  upstream strobe
wbi_we_i  in  1  1=push, 0=level read
wbi_dat_i  in  DATA_WIDTH  push data
wbi_stall_o  out  1  upstream stall
wbi_ack_o  out  1  upstream ack
wbi_dat_o  out  DATA_WIDTH  read data (zero-extended level)
wbo_cyc_o  out  1  downstream cycle
wbo_stb_o  out  1  downstream strobe
wbo_we_o  out  1  always 1 during cycle
wbo_dat_o  out  DATA_WIDTH  head entry
wbo_stall_i  in  1  downstream stall
wbo_ack_i  in  1  downstream ack
wbo_err_i  in  1  downstream error
level_o  out  ADDR_WIDTH+1  entry count, 0..DEPTH
full_o  out  1  level==DEPTH
empty_o  out  1  level==0
almost_full_o  out  1  level>=AF_THRESH
almost_empty_o  out  1  level<=AE_THRESH

Behaviour:
- Reset: async assert, sync deassert by the system. All outputs 0 except empty_o=1 and almost_empty_o=1. Pointers, level, FSM=IDLE. Storage is not reset.
- Upstream accept = cyc & stb & !stall_o.
  - wbi_stall_o = full_o (registered level).
  - Accepted write pushes wbi_dat_i.
  - Accepted read returns level.
  - wbi_ack_o is registered, exactly 1 cycle after accept; wbi_dat_o is valid with the ack, 0 otherwise.
  - Back-to-back accepts allowed: one per cycle.
- Push at full is impossible (stalled). A push is never dropped.
- Level: +1 on push only, -1 on pop only, unchanged on push and pop in the same cycle. Pointers wrap modulo DEPTH.
- Downstream FSM, all outputs registered:
  - IDLE: if !empty & !flush_i -> REQ. Set cyc/stb/we=1, load wbo_dat_o from head.
  - REQ: hold stb and dat while wbo_stall_i. On !stall -> WAIT. stb=0, cyc stays 1.
  - WAIT, ack_i: pop, cyc=0 -> IDLE.
  - WAIT, err_i: no pop, cyc=0 -> IDLE. The same head is retried.
  - ack_i or err_i in IDLE or REQ is ignored.
- Latency: push accepted at cycle N -> level_o updates at N+1 -> wbo_cyc_o rises at N+2.
- Minimum per-entry drain time is 3 cycles (IDLE, REQ, WAIT).
- Flush:
  - Level and pointers clear at the next edge; a same-cycle push is discarded.
  - An in-flight downstream cycle runs to completion, but its ack does not pop: the in-flight flag is cleared by flush.
  - flush_i overrides push and pop.
- Flags are derived from the registered level; no combinational path from inputs to any output.

Optional Feature:
WB_FIFO_BURST_EN
- Defined: in WAIT, ack_i with level>1 and no flush -> REQ directly. cyc_o is held high and the next head is loaded, giving 2 cycles/entry with cyc continuous across the burst.
- Undefined: always returns to IDLE with cyc=0 between entries.

Decomposition:
- wb_fifo_pkg holds:
  - ctrl_state_e enum {IDLE, REQ, WAIT}.
  - Function for level-width calculation.
- Sub-module wb_fifo_ptr: wrapping pointer with inc/clear inputs and parameter ADDR_WIDTH. Instantiated twice, for read and write.

Test Plan:
- Reset, DATA_WIDTH=16, ADDR_WIDTH=3. Push 0xA5A5; sink acks 1 cycle after accept -> wbo_dat_o=0xA5A5, cyc rises 2 cycles after accept, level returns to 0.
- Hold wbo_stall_i; push 8 entries -> full_o=1, wbi_stall_o=1, almost_full_o from level 6. 9th write is stalled, not acked.
- Downstream err_i on first entry 0x0011, ack on retry -> 0x0011 is sent twice, popped once, order preserved.
- Continuous push and pop with level 3 -> level_o stays 3. An upstream read returns 3 on wbi_dat_o.
- flush_i asserted in WAIT with 5 entries -> level 0 next cycle; the following ack does not underflow; no new cycle starts.
- WB_FIFO_BURST_EN, 4 entries, zero-stall sink -> cyc_o high continuously for 8 cycles.
